// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4 fetch/execute controller with ROM handshake, run/step/halt,
// address breakpoint and ROM-timeout fault.
module td4_sequencer #(
    parameter int ROM_TIMEOUT = 15,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   halt,
    input  logic                   bp_en,
    input  logic [3:0]             bp_addr,
    output logic                   rom_req,
    output logic [3:0]             rom_addr,
    input  logic                   rom_ack,
    input  logic [7:0]             rom_data,
    output logic [3:0]             opcode,
    output logic [3:0]             imm,
    input  logic                   carry_in,
    output logic                   carry_flag,
    output logic                   exec_en,
    output logic [3:0]             pc,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] instr_count
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;
    state_t state, state_nx;
    logic mode_run, mode_run_nx, halt_pend, halt_pend_nx, jump, stop;
    logic [7:0] tmo, tmo_nx;
    logic [3:0] pc_nx;
    assign rom_req  = state == FETCH;
    assign rom_addr = pc;
    assign exec_en  = state == EXEC;
    assign halted   = state == IDLE;
    assign fault    = state == FAULT;
    always_comb begin
        jump = opcode == 4'hf || (opcode == 4'he && !carry_flag);
        pc_nx = jump ? imm : pc + 4'd1;
        // run dropping while free-running behaves like a halt request
        stop = !mode_run || halt_pend || halt || !run || (bp_en && pc_nx == bp_addr);
        state_nx = state;
        mode_run_nx = mode_run;
        halt_pend_nx = halt_pend;
        tmo_nx = tmo;
        case (state)
            IDLE: begin
                halt_pend_nx = 1'b0;
                if (run || step) begin
                    state_nx = FETCH;
                    mode_run_nx = run;
                end
            end
            FETCH: begin
                halt_pend_nx = halt_pend || halt;
                tmo_nx = rom_ack ? 8'd0 : tmo + 8'd1;
                state_nx = rom_ack ? EXEC : (tmo == 8'(ROM_TIMEOUT - 1)) ? FAULT : FETCH;
            end
            EXEC: begin
                state_nx = stop ? IDLE : FETCH;
                halt_pend_nx = 1'b0;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_run    <= 1'b0;
            halt_pend   <= 1'b0;
            tmo         <= 8'd0;
            pc          <= 4'd0;
            carry_flag  <= 1'b0;
            opcode      <= 4'd0;
            imm         <= 4'd0;
            instr_count <= '0;
        end else begin
            state     <= state_nx;
            mode_run  <= mode_run_nx;
            halt_pend <= halt_pend_nx;
            tmo       <= tmo_nx;
            if (state == FETCH && rom_ack) begin
                opcode <= rom_data[7:4];
                imm    <= rom_data[3:0];
            end
            if (state == EXEC) begin
                carry_flag  <= carry_in;
                pc          <= pc_nx;
                instr_count <= instr_count + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
Multi-cycle fetch/execute controller for the TD4 core. It holds the PC and carry flag, fetches 8-bit instructions from an external ROM with a req/ack handshake, and presents opcode/immediate to the instruction decoder. It issues a one-cycle execute strobe that qualifies the decoder's register-load enables. It provides run/halt/single-step control, an address breakpoint, and a ROM-timeout fault.

Parameters:
ROM_TIMEOUT, 15, max cycles FETCH waits for rom_ack before faulting (1..255)
COUNT_WIDTH, 8, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  level; start/continue free-running execution
step  input  1  pulse; execute exactly one instruction from IDLE
halt  input  1  pulse; stop after the current instruction retires
bp_en  input  1  breakpoint enable
bp_addr  input  4  breakpoint PC
rom_req  output  1  fetch request, held until ack
rom_addr  output  4  fetch address (= pc while rom_req)
rom_ack  input  1  ROM data valid this cycle
rom_data  input  8  instruction word: [7:4] opcode, [3:0] immediate
opcode  output  4  latched opcode to decoder
imm  output  4  latched immediate to ALU/PC
carry_in  input  1  ALU carry-out of current instruction
carry_flag  output  1  registered carry flag (decoder C input)
exec_en  output  1  one-cycle strobe; register loads commit only when high
pc  output  4  program counter
halted  output  1  high in IDLE
fault  output  1  sticky ROM-timeout fault
instr_count  output  COUNT_WIDTH  retired instructions

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, pc=0, carry_flag=0, opcode=0, imm=0, rom_req=0, exec_en=0, halted=1, fault=0, instr_count=0, halt_pend=0, mode=STEP, timeout counter=0. Reset mid-fetch drops rom_req in the same edge; no exec_en.
- States: IDLE, FETCH, EXEC, FAULT.
- IDLE: halted=1. run=1 -> mode=RUN, go FETCH. Else step=1 -> mode=STEP, go FETCH. run wins if both are high. halt is ignored in IDLE and halt_pend is cleared.
- FETCH: rom_req=1, rom_addr=pc, timeout counter increments each cycle.
  - rom_ack=1: opcode<=rom_data[7:4], imm<=rom_data[3:0], counter cleared, rom_req deasserts next cycle, go EXEC.
  - Counter reaches ROM_TIMEOUT without ack: go FAULT.
  - Ack on the final allowed cycle counts as success.
- EXEC (exactly one cycle): exec_en=1.
  - carry_flag<=carry_in.
  - jump = (opcode==4'b1111) or (opcode==4'b1110 and carry_flag==0), using the pre-update carry_flag.
  - pc<=jump ? imm : pc+1, 4-bit wrap 15->0.
  - instr_count<=instr_count+1, wraps.
  - Next state:
    - IDLE if mode==STEP, or halt_pend, or halt=1 this cycle, or (bp_en and next pc==bp_addr).
    - Otherwise FETCH.
  - The breakpoint stops before fetching bp_addr. Resuming from IDLE always executes at least one instruction before the breakpoint is rechecked.
- halt pulse in FETCH sets halt_pend. The in-flight instruction still completes. halt_pend clears on entry to IDLE.
- run deasserted while running is treated as halt at the next EXEC.
- FAULT: fault=1, halted=0, rom_req=0, exec_en=0, pc frozen. Only rst_n exits FAULT.
- Latency: an instruction with 0-wait ack takes 2 cycles (FETCH, EXEC). Throughput is 1 instruction per (2+wait) cycles.
- Undefined opcodes: the sequencer still strobes exec_en and increments pc. Load suppression is the decoder's responsibility.

Test Plan:
- Reset then run=1, ROM acks same cycle with 0x35, 0x01 -> exec_en every 2nd cycle, pc 0->1->2, opcode 3 then 0, instr_count 2 after 4 cycles.
- JNC: carry_flag=0, fetch 0xE9 -> pc=9. With carry_flag=1, fetch 0xE9 -> pc=pc+1. JMP 0xF0 at pc=15 -> pc=0. Sequential pc 15 -> 0.
- step pulse from IDLE -> exactly one exec_en, back to IDLE, halted=1, pc advanced by 1. step+run together -> free-running.
- bp_en=1, bp_addr=3, run from pc 0 -> stops in IDLE with pc=3 after 3 instructions. run again -> executes pc 3, continues.
- halt pulse during a 4-cycle ack wait -> instruction still retires (one exec_en), then IDLE. rst_n low mid-FETCH -> rom_req=0 and all outputs at reset values next cycle.
- rom_ack held low -> fault=1 after ROM_TIMEOUT=15 FETCH cycles, no exec_en, stays faulted until rst_n=0.
